// File: rtl/conv_pkg.sv
// Shared encodings for the DDC receive-path arbiter.
package conv_pkg;

    // arb_mode encodings; 2'b11 behaves like ARB_FIX0
    localparam logic [1:0] ARB_FIX0 = 2'b00;
    localparam logic [1:0] ARB_FIX1 = 2'b01;
    localparam logic [1:0] ARB_RR   = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/conv_axis_oreg.sv
// Single-stage registered AXIS output slice (payload = tlast + tdata).
// load must only be asserted while load_rdy is high.
module conv_axis_oreg #(
    parameter int W = 33
) (
    input  logic         axis_clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         load_rdy,
    output logic         m_tvalid,
    output logic [W-1:0] m_payload,
    input  logic         m_tready
);

    assign load_rdy = ~m_tvalid | m_tready;

    // Hold the beat until taken; a new load may replace it in the same cycle it leaves
    always_ff @(posedge axis_clk) begin
        if (rst) begin
            m_tvalid  <= 1'b0;
            m_payload <= '0;
        end else if (load) begin
            m_tvalid  <= 1'b1;
            m_payload <= load_data;
        end else if (m_tready) begin
            m_tvalid  <= 1'b0;
        end
    end

endmodule

// File: rtl/conv_rx_arb.sv
// Packet-level arbiter sharing the DDC receive path between AXIS rx channels 0 and 1.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no packet owned; both treadys low; pick a candidate channel
// ST_PKT  | forwarding the packet of channel 'grant' until tlast or stall timeout
module conv_rx_arb
    import conv_pkg::*;
#(
    parameter int U_DLY       = 1,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              axis_clk,
    input  logic              rst,
    input  logic [1:0]        arb_mode,
    input  logic              s0_tvalid,
    input  logic              s0_tlast,
    input  logic [DATA_W-1:0] s0_tdata,
    output logic              s0_tready,
    input  logic              s1_tvalid,
    input  logic              s1_tlast,
    input  logic [DATA_W-1:0] s1_tdata,
    output logic              s1_tready,
    output logic              m_tvalid,
    output logic              m_tlast,
    output logic [DATA_W-1:0] m_tdata,
    input  logic              m_tready,
    output logic              grant,
    output logic              busy,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    output logic              to_pulse,
    output logic [7:0]        to_cnt
);

    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit WD_EN = (TIMEOUT_CYC > 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYC - 1) : '0;

    // U_DLY applies to simulation only; not used by this RTL
    logic unused_u_dly;
    assign unused_u_dly = (U_DLY != 0);

    arb_state_t        state;
    logic              last_grant;
    logic [WD_W-1:0]   wd;
    logic              out_rdy;
    logic              g_tvalid;
    logic              g_tlast;
    logic [DATA_W-1:0] g_tdata;
    logic              beat_acc;
    logic              wd_expire;
    logic              cand_vld;
    logic              cand;

    assign g_tvalid = grant ? s1_tvalid : s0_tvalid;
    assign g_tlast  = grant ? s1_tlast  : s0_tlast;
    assign g_tdata  = grant ? s1_tdata  : s0_tdata;

    assign s0_tready = (state == ST_PKT) && !grant && out_rdy;
    assign s1_tready = (state == ST_PKT) &&  grant && out_rdy;

    assign beat_acc  = (state == ST_PKT) && g_tvalid && out_rdy;
    // Only an absent source counts as a stall; backpressure from m_tready never does
    assign wd_expire = WD_EN && (state == ST_PKT) && !g_tvalid && (wd == WD_LAST);

    assign busy = (state == ST_PKT);

    // Candidate channel for the next packet; round-robin prefers the channel not served last
    always_comb begin
        cand_vld = 1'b0;
        cand     = 1'b0;
        case (arb_mode)
            ARB_FIX1: begin
                cand_vld = s1_tvalid;
                cand     = 1'b1;
            end
            ARB_RR: begin
                if (last_grant ? s0_tvalid : s1_tvalid) begin
                    cand_vld = 1'b1;
                    cand     = ~last_grant;
                end else if (last_grant ? s1_tvalid : s0_tvalid) begin
                    cand_vld = 1'b1;
                    cand     = last_grant;
                end
            end
            default: begin
                cand_vld = s0_tvalid;
                cand     = 1'b0;
            end
        endcase
    end

    // Arbitration FSM, stall watchdog and status counters
    always_ff @(posedge axis_clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            wd         <= '0;
            pkt_cnt0   <= '0;
            pkt_cnt1   <= '0;
            to_pulse   <= 1'b0;
            to_cnt     <= '0;
        end else begin
            to_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cand_vld) begin
                        grant <= cand;
                        wd    <= '0;
                        state <= ST_PKT;
                    end
                end
                ST_PKT: begin
                    if (beat_acc) begin
                        wd <= '0;
                        if (g_tlast) begin
                            if (grant) pkt_cnt1 <= pkt_cnt1 + 1'b1;
                            else       pkt_cnt0 <= pkt_cnt0 + 1'b1;
                            last_grant <= grant;
                            state      <= ST_IDLE;
                        end
                    end else if (wd_expire) begin
                        // Abandon the packet; downstream sees it truncated without tlast
                        to_pulse   <= 1'b1;
                        if (to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end else if (!g_tvalid && WD_EN) begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [DATA_W:0] m_payload;

    conv_axis_oreg #(
        .W (DATA_W + 1)
    ) u_oreg (
        .axis_clk  (axis_clk),
        .rst       (rst),
        .load      (beat_acc),
        .load_data ({g_tlast, g_tdata}),
        .load_rdy  (out_rdy),
        .m_tvalid  (m_tvalid),
        .m_payload (m_payload),
        .m_tready  (m_tready)
    );

    assign m_tlast = m_payload[DATA_W];
    assign m_tdata = m_payload[DATA_W-1:0];

endmodule

// File: tb/tb_conv_rx_arb.sv
// Directed bench for conv_rx_arb: queue-fed sources, beat/grant monitor, immediate assertions.
module tb_conv_rx_arb;

    logic        axis_clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  arb_mode = 2'b00;
    logic        s0_tvalid = 1'b0, s0_tlast = 1'b0;
    logic [31:0] s0_tdata = '0;
    logic        s0_tready;
    logic        s1_tvalid = 1'b0, s1_tlast = 1'b0;
    logic [31:0] s1_tdata = '0;
    logic        s1_tready;
    logic        m_tvalid, m_tlast;
    logic [31:0] m_tdata;
    logic        m_tready = 1'b0;
    logic        grant, busy;
    logic [15:0] pkt_cnt0, pkt_cnt1;
    logic        to_pulse;
    logic [7:0]  to_cnt;

    always #5 axis_clk = ~axis_clk;

    conv_rx_arb #(
        .U_DLY       (1),
        .DATA_W      (32),
        .CNT_W       (16),
        .TIMEOUT_CYC (8)
    ) dut (
        .axis_clk  (axis_clk),
        .rst       (rst),
        .arb_mode  (arb_mode),
        .s0_tvalid (s0_tvalid),
        .s0_tlast  (s0_tlast),
        .s0_tdata  (s0_tdata),
        .s0_tready (s0_tready),
        .s1_tvalid (s1_tvalid),
        .s1_tlast  (s1_tlast),
        .s1_tdata  (s1_tdata),
        .s1_tready (s1_tready),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tdata   (m_tdata),
        .m_tready  (m_tready),
        .grant     (grant),
        .busy      (busy),
        .pkt_cnt0  (pkt_cnt0),
        .pkt_cnt1  (pkt_cnt1),
        .to_pulse  (to_pulse),
        .to_cnt    (to_cnt)
    );

    typedef struct {
        logic [32:0] p;
        int          c;
    } beat_t;

    int          checks = 0;
    int          failures = 0;
    beat_t       mq[$];
    logic        gq[$];
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    int          cyc = 0;
    logic        acc0 = 1'b0, acc1 = 1'b0;
    logic        busy_q = 1'b0;
    logic        s1_rdy_seen = 1'b0;
    int          acc0_cyc = 0, pulse_cyc = 0, pulse_n = 0;
    logic        sv_valid = 1'b0, sv_ready = 1'b0, sv_rst = 1'b1;
    logic [32:0] sv_pay = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge axis_clk);
        #1;
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int k = 0;
        while (mq.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_beats"}, 64'(mq.size()), 64'(n));
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [32:0] exp);
        logic [32:0] obs;
        obs = (idx < mq.size()) ? mq[idx].p : 33'h0;
        chk(tag, 64'(obs), 64'(exp));
    endtask

    task automatic chk_gap(input string tag, input int idx, input int exp);
        int obs;
        obs = (idx < mq.size()) ? (mq[idx].c - mq[idx-1].c) : -1;
        chk(tag, 64'(obs), 64'(exp));
    endtask

    task automatic chk_grant(input string tag, input int idx, input logic exp);
        logic obs;
        obs = (idx < gq.size()) ? gq[idx] : 1'bx;
        chk(tag, 64'(obs), 64'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        q0.delete();
        q1.delete();
        tick();
        mq.delete();
        gq.delete();
        rst = 1'b0;
    endtask

    // Handshake capture, output beat log, grant log and stall-hold check on pre-edge values
    always @(posedge axis_clk) begin
        cyc  <= cyc + 1;
        acc0 <= s0_tvalid & s0_tready;
        acc1 <= s1_tvalid & s1_tready;
        if (!rst && m_tvalid && m_tready) mq.push_back('{p: {m_tlast, m_tdata}, c: cyc});
        if (!rst && busy && !busy_q) gq.push_back(grant);
        busy_q <= busy;
        if (s1_tready) s1_rdy_seen <= 1'b1;
        if (s0_tvalid && s0_tready) acc0_cyc <= cyc;
        if (to_pulse) begin
            pulse_cyc <= cyc;
            pulse_n   <= pulse_n + 1;
        end
        if (!rst && !sv_rst && sv_valid && !sv_ready)
            chk("hold_stable", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, sv_pay}));
        sv_valid <= m_tvalid;
        sv_ready <= m_tready;
        sv_rst   <= rst;
        sv_pay   <= {m_tlast, m_tdata};
    end

    // Sources: present the queue head, retire it after a captured handshake
    always @(negedge axis_clk) begin
        if (acc0 && q0.size() > 0) void'(q0.pop_front());
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        if (q0.size() > 0) begin
            s0_tvalid = 1'b1;
            {s0_tlast, s0_tdata} = q0[0];
        end else begin
            s0_tvalid = 1'b0;
            s0_tlast  = 1'b0;
            s0_tdata  = '0;
        end
        if (q1.size() > 0) begin
            s1_tvalid = 1'b1;
            {s1_tlast, s1_tdata} = q1[0];
        end else begin
            s1_tvalid = 1'b0;
            s1_tlast  = 1'b0;
            s1_tdata  = '0;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int k;
        logic [32:0] e;

        // Reset state
        repeat (3) tick();
        chk("rst_m", 64'({m_tvalid, m_tlast, m_tdata}), 64'h0);
        chk("rst_ctl", 64'({grant, busy, to_pulse, s0_tready, s1_tready}), 64'h0);
        chk("rst_cnt", 64'({pkt_cnt0, pkt_cnt1, to_cnt}), 64'h0);

        // 1: fixed ch0, 4-beat packet, ch1 pending but never served
        rst      = 1'b0;
        arb_mode = 2'b00;
        m_tready = 1'b1;
        q1.push_back({1'b1, 32'h999});
        for (int i = 0; i < 4; i++) q0.push_back({(i == 3), 32'(i + 1)});
        wait_beats(4, 40, "t1");
        for (int i = 0; i < 4; i++) chk_beat($sformatf("t1_b%0d", i), i, {(i == 3), 32'(i + 1)});
        for (int i = 1; i < 4; i++) chk_gap($sformatf("t1_gap%0d", i), i, 1);
        tick();
        tick();
        chk("t1_cnt0", 64'(pkt_cnt0), 64'd1);
        chk("t1_cnt1", 64'(pkt_cnt1), 64'd0);
        chk("t1_s1_rdy", 64'(s1_rdy_seen), 64'd0);

        // 2: round-robin, both channels streaming 3-beat packets
        do_reset();
        arb_mode = 2'b10;
        for (int i = 0; i < 6; i++) begin
            q0.push_back({(i % 3 == 2), 32'h100 + 32'(i + 1)});
            q1.push_back({(i % 3 == 2), 32'h200 + 32'(i + 1)});
        end
        wait_beats(6, 60, "t2a");
        chk("t2_pair1_cnt0", 64'(pkt_cnt0), 64'd1);
        chk("t2_pair1_cnt1", 64'(pkt_cnt1), 64'd1);
        wait_beats(12, 60, "t2b");
        for (int i = 0; i < 12; i++) begin
            e = {((i % 3) == 2), (((i / 3) % 2 == 1) ? 32'h200 : 32'h100) + 32'(3 * (i / 6) + (i % 3) + 1)};
            chk_beat($sformatf("t2_b%0d", i), i, e);
        end
        for (int i = 1; i < 12; i++) chk_gap($sformatf("t2_gap%0d", i), i, (i % 3 == 0) ? 2 : 1);
        chk("t2_ngrant", 64'(gq.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk_grant($sformatf("t2_g%0d", i), i, 1'(i % 2));
        tick();
        tick();
        chk("t2_cnt0", 64'(pkt_cnt0), 64'd2);
        chk("t2_cnt1", 64'(pkt_cnt1), 64'd2);

        // 3: round-robin with m_tready toggling; ch0 is next after ch1
        mq.delete();
        gq.delete();
        for (int i = 0; i < 5; i++) q0.push_back({(i == 4), 32'h301 + 32'(i)});
        k = 0;
        while (mq.size() < 5 && k < 80) begin
            m_tready = ~m_tready;
            tick();
            k++;
        end
        chk("t3_beats", 64'(mq.size()), 64'd5);
        for (int i = 0; i < 5; i++) chk_beat($sformatf("t3_b%0d", i), i, {(i == 4), 32'h301 + 32'(i)});
        chk_grant("t3_g0", 0, 1'b0);
        m_tready = 1'b1;
        tick();
        tick();
        chk("t3_cnt0", 64'(pkt_cnt0), 64'd3);

        // 5: mode 00 -> 01 while ch0 packet in flight
        mq.delete();
        gq.delete();
        arb_mode = 2'b00;
        for (int i = 0; i < 4; i++) q0.push_back({(i == 3), 32'h501 + 32'(i)});
        q1.push_back({1'b0, 32'h601});
        q1.push_back({1'b1, 32'h602});
        wait_beats(2, 30, "t5a");
        arb_mode = 2'b01;
        wait_beats(6, 60, "t5b");
        for (int i = 0; i < 4; i++) chk_beat($sformatf("t5_b%0d", i), i, {(i == 3), 32'h501 + 32'(i)});
        chk_beat("t5_b4", 4, {1'b0, 32'h601});
        chk_beat("t5_b5", 5, {1'b1, 32'h602});
        chk_grant("t5_g0", 0, 1'b0);
        chk_grant("t5_g1", 1, 1'b1);
        tick();
        chk("t5_cnt", 64'({pkt_cnt0, pkt_cnt1}), 64'({16'd4, 16'd3}));

        // 4: ch0 stalls after 2 beats, watchdog expires, ch1 served next
        mq.delete();
        gq.delete();
        arb_mode = 2'b10;
        q0.push_back({1'b0, 32'h401});
        q0.push_back({1'b0, 32'h402});
        q1.push_back({1'b0, 32'h701});
        q1.push_back({1'b1, 32'h702});
        wait_beats(4, 60, "t4");
        tick();
        tick();
        chk("t4_npulse", 64'(pulse_n), 64'd1);
        chk("t4_pulse_dly", 64'(pulse_cyc - acc0_cyc), 64'd9);
        chk("t4_to_cnt", 64'(to_cnt), 64'd1);
        chk("t4_cnt", 64'({pkt_cnt0, pkt_cnt1}), 64'({16'd4, 16'd4}));
        chk_beat("t4_b0", 0, {1'b0, 32'h401});
        chk_beat("t4_b1", 1, {1'b0, 32'h402});
        chk_beat("t4_b2", 2, {1'b0, 32'h701});
        chk_beat("t4_b3", 3, {1'b1, 32'h702});
        chk_grant("t4_g0", 0, 1'b0);
        chk_grant("t4_g1", 1, 1'b1);
        chk("t4_idle", 64'(busy), 64'd0);

        // 6: reset while beat 2 sits in the output register
        mq.delete();
        gq.delete();
        arb_mode = 2'b00;
        for (int i = 0; i < 4; i++) q0.push_back({(i == 3), 32'h801 + 32'(i)});
        wait_beats(1, 30, "t6a");
        chk("t6_pre_valid", 64'(m_tvalid), 64'd1);
        rst = 1'b1;
        tick();
        chk("t6_m", 64'({m_tvalid, m_tlast, m_tdata}), 64'h0);
        chk("t6_ctl", 64'({grant, busy, to_pulse, s0_tready, s1_tready}), 64'h0);
        chk("t6_cnt", 64'({pkt_cnt0, pkt_cnt1, to_cnt}), 64'h0);
        q0.delete();
        q1.delete();
        tick();
        mq.delete();
        gq.delete();
        rst = 1'b0;
        arb_mode = 2'b10;
        q0.push_back({1'b0, 32'h901});
        q0.push_back({1'b1, 32'h902});
        q1.push_back({1'b1, 32'hA01});
        wait_beats(3, 40, "t6b");
        chk_beat("t6_b0", 0, {1'b0, 32'h901});
        chk_beat("t6_b1", 1, {1'b1, 32'h902});
        chk_beat("t6_b2", 2, {1'b1, 32'hA01});
        chk_grant("t6_g0", 0, 1'b0);
        chk_grant("t6_g1", 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
